// File: rtl/mlp_tile_pkg.sv
// Shared types and signed fixed-point helpers for the MLP forward tile.
// Helpers work on 64-bit sign-extended operands; callers truncate to DW.
package mlp_tile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L0_MAC,
        L0_ACT,
        L1_MAC,
        L1_ACT,
        ARGMAX,
        DONE
    } state_t;

    localparam int unsigned FP_FRAC = 16;
    localparam logic signed [63:0] ONE = 64'sd1 <<< FP_FRAC;

    // Operands must fit in 32 bits so the full product fits in 64.
    function automatic logic signed [63:0] mul(input logic signed [63:0] a,
                                               input logic signed [63:0] b,
                                               input int unsigned frac);
        logic signed [63:0] p;
        p = a * b;
        return p >>> frac;
    endfunction

    function automatic logic signed [63:0] act(input logic signed [63:0] x,
                                               input int unsigned frac);
        logic signed [63:0] one;
        logic signed [63:0] y;
        one = 64'sd1 <<< frac;
        y = (x >>> 2) + (one >>> 1);
        if (y < 0) begin
            y = '0;
        end else if (y > one) begin
            y = one;
        end
        return y;
    endfunction

endpackage

// File: rtl/mlp_fwd_tile_mac_unit.sv
// Single fixed-point multiply-accumulate lane; accumulator wraps modulo 2^DW.
module mac_unit
    import mlp_tile_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] weight,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] acc
);

    logic signed [63:0] prod;

    always_comb begin
        prod = mul(64'($signed(weight)), 64'($signed(data)), FRAC);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + DW'(prod);
        end
    end

endmodule

// File: rtl/mlp_fwd_tile.sv
// Two-layer MLP forward pass: weight columns stream in one beat per input
// element, hard-sigmoid activations, argmax and optional training error.
module mlp_fwd_tile
    import mlp_tile_pkg::*;
#(
    parameter int unsigned IN_SZ  = 784,
    parameter int unsigned HID_SZ = 128,
    parameter int unsigned OUT_SZ = 10,
    parameter int unsigned DW     = 32,
    parameter int unsigned FRAC   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      train,
    input  logic                      abort,
    input  logic [IN_SZ*DW-1:0]       image,
    input  logic [7:0]                label,
    input  logic                      w0_valid,
    output logic                      w0_ready,
    input  logic [HID_SZ*DW-1:0]      w0_data,
    input  logic                      w1_valid,
    output logic                      w1_ready,
    input  logic [OUT_SZ*DW-1:0]      w1_data,
    output logic                      busy,
    output logic                      done,
    output logic [OUT_SZ*DW-1:0]      result,
    output logic [$clog2(OUT_SZ)-1:0] class_idx,
    output logic [OUT_SZ*DW-1:0]      err,
    output logic                      err_valid
);

    localparam int unsigned CW  = $clog2(OUT_SZ);
    localparam int unsigned I0W = $clog2(IN_SZ);
    localparam int unsigned I1W = $clog2(HID_SZ);
    localparam logic [I0W-1:0] LAST0 = I0W'(IN_SZ - 1);
    localparam logic [I1W-1:0] LAST1 = I1W'(HID_SZ - 1);
    localparam logic [DW-1:0]  ONE_L = DW'(64'sd1 <<< FRAC);

    state_t         state_q, state_d;
    logic [DW-1:0]  img_q   [IN_SZ];
    logic [DW-1:0]  hidden  [HID_SZ];
    logic [DW-1:0]  res_int [OUT_SZ];
    logic [DW-1:0]  acc0    [HID_SZ];
    logic [DW-1:0]  acc1    [OUT_SZ];
    logic [DW-1:0]  err_d   [OUT_SZ];
    logic [I0W-1:0] idx0;
    logic [I1W-1:0] idx1;
    logic [7:0]     label_q;
    logic           train_q;
    logic           accept, halt, beat0, beat1, clear_acc;
    logic [CW-1:0]  best;

    always_comb begin
        accept    = (state_q == IDLE) && start;
        halt      = (state_q != IDLE) && abort;
        w0_ready  = (state_q == L0_MAC) && !abort && !rst;
        w1_ready  = (state_q == L1_MAC) && !abort && !rst;
        beat0     = w0_valid && w0_ready;
        beat1     = w1_valid && w1_ready;
        clear_acc = rst || accept;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE) && !abort;
    end

    for (genvar n = 0; n < HID_SZ; n++) begin : g_l0
        mac_unit #(.DW(DW), .FRAC(FRAC)) u_mac (
            .clk    (clk),
            .clear  (clear_acc),
            .en     (beat0),
            .weight (w0_data[n*DW +: DW]),
            .data   (img_q[idx0]),
            .acc    (acc0[n])
        );
    end

    for (genvar k = 0; k < OUT_SZ; k++) begin : g_l1
        mac_unit #(.DW(DW), .FRAC(FRAC)) u_mac (
            .clk    (clk),
            .clear  (clear_acc),
            .en     (beat1),
            .weight (w1_data[k*DW +: DW]),
            .data   (hidden[idx1]),
            .acc    (acc1[k])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = L0_MAC;
            L0_MAC:  if (beat0 && idx0 == LAST0) state_d = L0_ACT;
            L0_ACT:  state_d = L1_MAC;
            L1_MAC:  if (beat1 && idx1 == LAST1) state_d = L1_ACT;
            L1_ACT:  state_d = ARGMAX;
            ARGMAX:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (halt) begin
            state_d = IDLE;
        end
    end

    // Strict '>' keeps the earliest index on ties.
    always_comb begin
        best = '0;
        for (int unsigned k = 1; k < OUT_SZ; k++) begin
            if ($signed(res_int[k]) > $signed(res_int[best])) begin
                best = CW'(k);
            end
        end
        for (int unsigned k = 0; k < OUT_SZ; k++) begin
            err_d[k] = ((32'(label_q) == k) ? ONE_L : '0) - res_int[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx0      <= '0;
            idx1      <= '0;
            label_q   <= '0;
            train_q   <= 1'b0;
            result    <= '0;
            err       <= '0;
            class_idx <= '0;
            err_valid <= 1'b0;
            for (int unsigned i = 0; i < IN_SZ; i++) img_q[i] <= '0;
            for (int unsigned n = 0; n < HID_SZ; n++) hidden[n] <= '0;
            for (int unsigned k = 0; k < OUT_SZ; k++) res_int[k] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int unsigned i = 0; i < IN_SZ; i++) img_q[i] <= image[i*DW +: DW];
                        label_q   <= label;
                        train_q   <= train;
                        idx0      <= '0;
                        idx1      <= '0;
                        err_valid <= 1'b0;
                    end
                end
                L0_MAC: if (beat0) idx0 <= (idx0 == LAST0) ? '0 : idx0 + 1'b1;
                L0_ACT: begin
                    if (!abort) begin
                        for (int unsigned n = 0; n < HID_SZ; n++)
                            hidden[n] <= DW'(act(64'($signed(acc0[n])), FRAC));
                    end
                end
                L1_MAC: if (beat1) idx1 <= (idx1 == LAST1) ? '0 : idx1 + 1'b1;
                L1_ACT: begin
                    if (!abort) begin
                        for (int unsigned k = 0; k < OUT_SZ; k++)
                            res_int[k] <= DW'(act(64'($signed(acc1[k])), FRAC));
                    end
                end
                // Visible outputs commit here so an abort earlier leaves them intact.
                ARGMAX: begin
                    if (!abort) begin
                        for (int unsigned k = 0; k < OUT_SZ; k++) begin
                            result[k*DW +: DW] <= res_int[k];
                            if (train_q) err[k*DW +: DW] <= err_d[k];
                        end
                        class_idx <= best;
                        err_valid <= train_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_fwd_tile.sv
// Directed bench for mlp_fwd_tile with a small 4-2-3 configuration.
module tb_mlp_fwd_tile;

    localparam int IN_SZ = 4, HID_SZ = 2, OUT_SZ = 3, DW = 32, FRAC = 16;

    typedef struct {
        logic [31:0] img [4];
        logic [31:0] w0  [4][2];
        logic [31:0] w1  [2][3];
        logic        train;
        logic [7:0]  label;
        logic [31:0] exp_res [3];
        logic [1:0]  exp_cls;
        logic [31:0] exp_err [3];
        logic        exp_ev;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst, start, train, abort;
    logic [IN_SZ*DW-1:0]  image;
    logic [7:0]           label;
    logic                 w0_valid, w0_ready, w1_valid, w1_ready;
    logic [HID_SZ*DW-1:0] w0_data;
    logic [OUT_SZ*DW-1:0] w1_data;
    logic                 busy, done, err_valid;
    logic [OUT_SZ*DW-1:0] result, err;
    logic [1:0]           class_idx;

    always #5 clk = ~clk;

    mlp_fwd_tile #(.IN_SZ(IN_SZ), .HID_SZ(HID_SZ), .OUT_SZ(OUT_SZ), .DW(DW), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .train(train), .abort(abort),
        .image(image), .label(label),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_data(w0_data),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_data(w1_data),
        .busy(busy), .done(done), .result(result), .class_idx(class_idx),
        .err(err), .err_valid(err_valid)
    );

    vec_t       cur;
    vec_t       vecs [6];
    logic [1:0] b0;
    logic       b1;
    logic       tb_clr;
    int         stall_cnt, stall_at, stall_len;
    int         n_cmp = 0, n_bad = 0;

    always @(posedge clk) begin
        if (tb_clr) begin
            b0 <= '0; b1 <= '0; stall_cnt <= 0;
        end else begin
            if (w0_valid && w0_ready) b0 <= b0 + 2'd1;
            if (w1_valid && w1_ready) b1 <= b1 + 1'b1;
            if (w0_ready && stall_len > 0 && int'(b0) == stall_at && stall_cnt < stall_len)
                stall_cnt <= stall_cnt + 1;
        end
    end

    always_comb begin
        w0_valid = !(stall_len > 0 && int'(b0) == stall_at && stall_cnt < stall_len);
        w1_valid = 1'b1;
        for (int n = 0; n < HID_SZ; n++) w0_data[n*DW +: DW] = cur.w0[b0][n];
        for (int k = 0; k < OUT_SZ; k++) w1_data[k*DW +: DW] = cur.w1[b1][k];
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clr(output vec_t v);
        for (int i = 0; i < 4; i++) begin
            v.img[i] = '0;
            for (int n = 0; n < 2; n++) v.w0[i][n] = '0;
        end
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++) v.w1[i][k] = '0;
        for (int k = 0; k < 3; k++) begin
            v.exp_res[k] = 32'h8000;
            v.exp_err[k] = '0;
        end
        v.train = 1'b0; v.label = '0; v.exp_cls = '0; v.exp_ev = 1'b0;
    endtask

    task automatic start_only(input vec_t v);
        cur = v;
        @(negedge clk);
        for (int i = 0; i < IN_SZ; i++) image[i*DW +: DW] = v.img[i];
        label = v.label; train = v.train; start = 1'b1; tb_clr = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; tb_clr = 1'b0;
    endtask

    // lat counts cycles after the start-sampling edge until done is seen.
    task automatic run_pass(input vec_t v, input int restart_at, output int lat);
        start_only(v);
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            start = (c == restart_at);
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, "_result"}, 96'(result), {v.exp_res[2], v.exp_res[1], v.exp_res[0]});
        chk({tag, "_class"}, 96'(class_idx), 96'(v.exp_cls));
        chk({tag, "_err_valid"}, 96'(err_valid), 96'(v.exp_ev));
        if (v.exp_ev) chk({tag, "_err"}, 96'(err), {v.exp_err[2], v.exp_err[1], v.exp_err[0]});
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 96'(done), 96'(0));
        chk({tag, "_busy_after"}, 96'(busy), 96'(0));
    endtask

    initial begin
        int lat;
        int dcount;
        rst = 1'b1; start = 1'b0; train = 1'b0; abort = 1'b0; image = '0; label = '0;
        stall_at = 0; stall_len = 0; tb_clr = 1'b1;
        for (int i = 0; i < 6; i++) clr(vecs[i]);
        // 1: all-zero weights, inference only
        // 2: all-zero weights, train label 1
        vecs[1].train = 1'b1; vecs[1].label = 8'd1; vecs[1].exp_ev = 1'b1;
        vecs[1].exp_err = '{32'hFFFF8000, 32'h00008000, 32'hFFFF8000};
        // 3: both clamp limits in layer 0, hidden observed through w1
        vecs[2].img[0] = 32'h10000;
        vecs[2].w0[0] = '{32'h40000, 32'hFFFC0000};
        vecs[2].w1[0] = '{32'h10000, 32'h40000, 32'hFFFF0000};
        vecs[2].w1[1] = '{32'h10000, 32'h10000, 32'h10000};
        vecs[2].train = 1'b1; vecs[2].label = 8'd2; vecs[2].exp_ev = 1'b1;
        vecs[2].exp_res = '{32'hC000, 32'h10000, 32'h4000}; vecs[2].exp_cls = 2'd1;
        vecs[2].exp_err = '{32'hFFFF4000, 32'hFFFF0000, 32'h0000C000};
        // 4: out-of-range label gives zero ideal
        vecs[3] = vecs[2]; vecs[3].label = 8'd5;
        vecs[3].exp_err = '{32'hFFFF4000, 32'hFFFF0000, 32'hFFFFC000};
        // 5: tie between classes 1 and 2
        vecs[4].img[0] = 32'h10000;
        vecs[4].w0[0] = '{32'h40000, 32'h0};
        vecs[4].w1[0] = '{32'h0, 32'h10000, 32'h10000};
        vecs[4].exp_res = '{32'h8000, 32'hC000, 32'hC000}; vecs[4].exp_cls = 2'd1;
        // 6: fractional products on the last beat, negative layer-1 weight
        vecs[5].img[0] = 32'h10000; vecs[5].img[3] = 32'h20000;
        vecs[5].w0[1] = '{32'h30000, 32'h30000};
        vecs[5].w0[3] = '{32'h8000, 32'h0};
        vecs[5].w1[0] = '{32'h20000, 32'hFFFE0000, 32'h0};
        vecs[5].train = 1'b1; vecs[5].label = 8'd0; vecs[5].exp_ev = 1'b1;
        vecs[5].exp_res = '{32'hE000, 32'h2000, 32'h8000}; vecs[5].exp_cls = 2'd0;
        vecs[5].exp_err = '{32'h2000, 32'hFFFFE000, 32'hFFFF8000};
        cur = vecs[0];

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; tb_clr = 1'b0;
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_w0_ready", 96'(w0_ready), 96'(0));
        chk("rst_w1_ready", 96'(w1_ready), 96'(0));
        chk("rst_outputs", {result, err_valid, class_idx}, 96'(0));
        chk("rst_err", 96'(err), 96'(0));

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i], 0, lat);
            chk($sformatf("v%0d_latency", i), 96'(lat), 96'(10));
            check_out($sformatf("v%0d", i), vecs[i]);
            after_done($sformatf("v%0d", i));
        end

        // Three stall cycles in layer 0 add three cycles
        stall_at = 2; stall_len = 3;
        run_pass(vecs[0], 0, lat);
        chk("stall_latency", 96'(lat), 96'(13));
        check_out("stall", vecs[0]);
        after_done("stall");
        stall_len = 0;

        // Abort in L1_MAC keeps the previous outputs
        run_pass(vecs[2], 0, lat);
        chk("pre_abort_latency", 96'(lat), 96'(10));
        start_only(vecs[0]);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (w1_ready) break;
            @(posedge clk);
        end
        chk("abort_reached_l1", 96'(w1_ready), 96'(1));
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 96'(busy), 96'(0));
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 96'(dcount), 96'(0));
        chk("abort_result_kept", 96'(result), {vecs[2].exp_res[2], vecs[2].exp_res[1], vecs[2].exp_res[0]});
        chk("abort_class_kept", 96'(class_idx), 96'(vecs[2].exp_cls));
        chk("abort_err_valid", 96'(err_valid), 96'(0));
        run_pass(vecs[0], 0, lat);
        chk("post_abort_latency", 96'(lat), 96'(10));
        check_out("post_abort", vecs[0]);

        // Start pulsed mid-pass is ignored
        run_pass(vecs[5], 3, lat);
        chk("restart_latency", 96'(lat), 96'(10));
        check_out("restart", vecs[5]);
        after_done("restart");

        // Reset in the middle of L0_MAC
        start_only(vecs[2]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 96'(busy), 96'(0));
        chk("midrst_ready", {w0_ready, w1_ready, done}, 96'(0));
        chk("midrst_outputs", {result, err_valid, class_idx}, 96'(0));
        chk("midrst_err", 96'(err), 96'(0));
        run_pass(vecs[1], 0, lat);
        chk("post_rst_latency", 96'(lat), 96'(10));
        check_out("post_rst", vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
